// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// mul_div_unit_pkg : shared op encodings, FSM state type and op decode helpers
// Revision: 1.0
// ============================================================================
package mul_div_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Multi-cycle ops occupy the lower half of the encoding space.
  function automatic logic op_is_calc(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
// mul_div_unit_if : request/result bundle between a requester and mul_div_unit
// Revision: 1.0
// ============================================================================
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       mdOp;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic             flush;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, mdOp, din1, din2, flush,
    input  busy, done, divByZero, hi, lo
  );

  modport slave (
    input  start, mdOp, din1, din2, flush,
    output busy, done, divByZero, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit_div_step.sv
`default_nettype none
// ============================================================================
// div_restore_step : one combinational restoring-division step on magnitudes
// Revision: 1.0
// ============================================================================
module div_restore_step
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor always holds, so the borrow bit alone decides the step.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// mul_div_unit : iterative HI/LO multiply/divide unit (shift-add / restoring)
// Revision: 1.0
// ============================================================================
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CW-1:0]    iter;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             zero_div;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic               sgn;
  logic               neg1;
  logic               neg2;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc;
  logic [WIDTH-1:0]   mul_low;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               q_bit;
  logic               last;

  always_comb begin
    sgn      = op_is_signed(bus.mdOp);
    neg1     = sgn & bus.din1[WIDTH-1];
    neg2     = sgn & bus.din2[WIDTH-1];
    abs1     = neg1 ? -bus.din1 : bus.din1;
    abs2     = neg2 ? -bus.din2 : bus.din2;
    // {acc,low} holds partial product above the not-yet-consumed multiplier bits.
    mul_sum  = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
    mul_acc  = mul_sum[WIDTH:1];
    mul_low  = {mul_sum[0], low[WIDTH-1:1]};
    prod     = {mul_acc, mul_low};
    prod_fix = neg_q ? -prod : prod;
    quo_next = {low[WIDTH-2:0], q_bit};
    quo_fix  = neg_q ? -quo_next : quo_next;
    rem_fix  = neg_r ? -rem_next : rem_next;
    last     = (iter == CW'(WIDTH - 1));
  end

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in  (acc),
    .bit_in  (low[WIDTH-1]),
    .divisor (opnd),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      iter     <= '0;
      acc      <= '0;
      low      <= '0;
      opnd     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.flush) begin
            if (bus.mdOp == OP_MTHI) begin
              hi_q <= bus.din1;
            end else if (bus.mdOp == OP_MTLO) begin
              lo_q <= bus.din1;
            end else if (op_is_calc(bus.mdOp)) begin
              state    <= ST_CALC;
              busy_q   <= 1'b1;
              iter     <= '0;
              acc      <= '0;
              is_div   <= op_is_div(bus.mdOp);
              neg_q    <= neg1 ^ neg2;
              neg_r    <= neg1;
              zero_div <= (bus.din2 == '0);
              if (op_is_div(bus.mdOp)) begin
                opnd <= abs2;
                low  <= abs1;
              end else begin
                opnd <= abs1;
                low  <= abs2;
              end
            end
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            iter   <= '0;
          end else begin
            iter <= iter + CW'(1);
            if (is_div) begin
              acc <= rem_next;
              low <= quo_next;
            end else begin
              acc <= mul_acc;
              low <= mul_low;
            end
            // Result commits on the final CALC edge so it is visible with done.
            if (last) begin
              state  <= ST_FINISH;
              done_q <= 1'b1;
              dbz_q  <= is_div & zero_div;
              if (!is_div) begin
                {hi_q, lo_q} <= prod_fix;
              end else if (!zero_div) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
              end
            end
          end
        end
        ST_FINISH: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          iter   <= '0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          iter   <= '0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.divByZero = dbz_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mul_div_unit : directed vectors with a transaction-level reference model
// Revision: 1.0
// ============================================================================
module tb_mul_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result of one operation from plain integer arithmetic.
  function automatic void model_calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint          sa, sb, sp;
    longint unsigned up;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    h  = '0;
    l  = '0;
    z  = 1'b0;
    case (op)
      3'b000: begin sp = sa * sb; h = sp[2*W-1:W]; l = sp[W-1:0]; end
      3'b001: begin up = {32'b0, a} * {32'b0, b}; h = up[2*W-1:W]; l = up[W-1:0]; end
      3'b010: begin
        if (b == '0) z = 1'b1;
        else begin sp = sa / sb; l = sp[W-1:0]; sp = sa % sb; h = sp[W-1:0]; end
      end
      3'b011: begin
        if (b == '0) z = 1'b1;
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction

  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         p_z = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  int           left = 0;

  // left = busy cycles still to come; result lands when only the FINISH cycle remains.
  always @(posedge clk) begin
    m_done = 1'b0;
    m_dbz  = 1'b0;
    if (rst) begin
      m_hi = '0; m_lo = '0; left = 0;
    end else if (left > 0) begin
      if (bus.flush) left = 0;
      else begin
        left--;
        if (left == 1) begin
          m_done = 1'b1;
          m_dbz  = p_z;
          if (!p_z) begin m_hi = p_hi; m_lo = p_lo; end
        end
      end
    end else if (bus.start && !bus.flush) begin
      case (bus.mdOp)
        3'b100: m_hi = bus.din1;
        3'b101: m_lo = bus.din1;
        3'b000, 3'b001, 3'b010, 3'b011: begin
          model_calc(bus.mdOp, bus.din1, bus.din2, p_hi, p_lo, p_z);
          left = W + 1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      W'(bus.busy),      W'(left > 0));
      check("done",      W'(bus.done),      W'(m_done));
      check("divByZero", W'(bus.divByZero), W'(m_dbz));
      check("hi",        bus.hi,            m_hi);
      check("lo",        bus.lo,            m_lo);
    end
  end

  // Start in cycle 0, return at the negedge of the done cycle (dc) or dc=-1 on timeout.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int dc);
    dc = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.mdOp = op; bus.din1 = a; bus.din2 = b;
    for (int k = 1; k <= W + 8 && dc < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.start = 1'b0; bus.din1 = $urandom; bus.din2 = $urandom; end
      if (bus.done === 1'b1) dc = k;
    end
  endtask

  task automatic single(input logic [2:0] op, input logic [W-1:0] a, input logic fl);
    @(negedge clk);
    bus.start = 1'b1; bus.mdOp = op; bus.din1 = a; bus.flush = fl;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
  endtask

  initial begin
    int dc;
    int dones;
    bus.start = 1'b0; bus.mdOp = '0; bus.din1 = '0; bus.din2 = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", W'(bus.busy), 32'h0);
    check("rst_done", W'(bus.done), 32'h0);
    rst = 1'b0;

    run_op(3'b000, 32'hFFFF_FFFF, 32'd5, dc);
    check("mult_cycle", dc, 33);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFB);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc);
    check("multu_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo, 32'h0000_0001);
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, dc);
    check("mult_minmin_hi", bus.hi, 32'h4000_0000);
    check("mult_minmin_lo", bus.lo, 32'h0);
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, dc);
    check("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(3'b011, 32'd7, 32'd2, dc);
    check("divu_lo", bus.lo, 32'd3);
    check("divu_hi", bus.hi, 32'd1);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, dc);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'h0);
    check("div_ovf_dbz", W'(bus.divByZero), 32'h0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'd3, dc);
    check("divu_big_lo", bus.lo, 32'h5555_5555);

    single(3'b100, 32'd1, 1'b0);
    check("mthi_hi", bus.hi, 32'd1);
    single(3'b101, 32'd2, 1'b0);
    check("mtlo_lo", bus.lo, 32'd2);
    run_op(3'b010, 32'd9, 32'd0, dc);
    check("dbz_cycle", dc, 33);
    check("dbz_flag", W'(bus.divByZero), 32'h1);
    check("dbz_hi", bus.hi, 32'd1);
    check("dbz_lo", bus.lo, 32'd2);

    run_op(3'b010, 32'd100, 32'hFFFF_FFF9, dc);
    check("div_mixed_lo", bus.lo, 32'hFFFF_FFF2);
    check("div_mixed_hi", bus.hi, 32'd2);

    // Flush mid-multiply, with an mthi attempt while busy.
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mdOp = 3'b001; bus.din1 = 32'd3; bus.din2 = 32'd4;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 5) begin bus.start = 1'b1; bus.mdOp = 3'b100; bus.din1 = 32'hDEAD_BEEF; end
      if (k == 6) bus.start = 1'b0;
      if (k == 10) begin check("flush_busy_before", W'(bus.busy), 32'h1); bus.flush = 1'b1; end
      if (k == 11) begin bus.flush = 1'b0; check("flush_busy_low", W'(bus.busy), 32'h0); end
      if (bus.done === 1'b1) dones++;
    end
    check("flush_no_done", dones, 0);
    check("flush_hi", bus.hi, 32'd2);
    check("flush_lo", bus.lo, 32'hFFFF_FFF2);

    run_op(3'b001, 32'd3, 32'd4, dc);
    check("multu_small_lo", bus.lo, 32'd12);
    check("multu_small_hi", bus.hi, 32'd0);

    single(3'b100, 32'h1234_5678, 1'b0);
    check("mthi2_hi", bus.hi, 32'h1234_5678);
    check("mthi2_busy", W'(bus.busy), 32'h0);
    single(3'b110, 32'hAAAA_AAAA, 1'b0);
    check("rsvd_busy", W'(bus.busy), 32'h0);
    single(3'b101, 32'h5555_5555, 1'b1);
    check("flush_start_lo", bus.lo, 32'd12);
    single(3'b000, 32'd3, 1'b1);
    check("flush_start_busy", W'(bus.busy), 32'h0);

    // Reset in cycle 20 of a divide.
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mdOp = 3'b010; bus.din1 = 32'd100; bus.din2 = 32'd7;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 20) rst = 1'b1;
      if (k == 21) begin
        rst = 1'b0;
        check("rst_mid_hi", bus.hi, 32'h0);
        check("rst_mid_lo", bus.lo, 32'h0);
        check("rst_mid_busy", W'(bus.busy), 32'h0);
      end
      if (bus.done === 1'b1) dones++;
    end
    check("rst_mid_no_done", dones, 0);

    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.mdOp = 3'b000; bus.din1 = 32'd3; bus.din2 = 32'd3; bus.flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0; bus.flush = 1'b0;
    check("rst_start_busy", W'(bus.busy), 32'h0);

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, dc);
    check("mult_neg_cycle", dc, 33);
    check("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", bus.lo, 32'hFFFF_FFEB);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
